// File: rtl/axi64_sram_slave_if.sv
// AXI3-style 64-bit bus bundle between the debug bridge master and the SRAM slave.
interface axi64_sram_slave_if #(
   parameter int P_AXI_IDWIDTH = 5
);
   logic [31:0]              axis_awaddr;
   logic [7:0]               axis_awlen;
   logic [2:0]               axis_awsize;
   logic [1:0]               axis_awburst;
   logic [P_AXI_IDWIDTH-1:0] axis_awid;
   logic                     axis_awvalid;
   logic                     axis_awready;
   logic [63:0]              axis_wdata;
   logic [7:0]               axis_wstrb;
   logic                     axis_wlast;
   logic                     axis_wvalid;
   logic                     axis_wready;
   logic [P_AXI_IDWIDTH-1:0] axis_bid;
   logic [1:0]               axis_bresp;
   logic                     axis_bvalid;
   logic                     axis_bready;
   logic [31:0]              axis_araddr;
   logic [3:0]               axis_arlen;
   logic [2:0]               axis_arsize;
   logic [1:0]               axis_arburst;
   logic [P_AXI_IDWIDTH-1:0] axis_arid;
   logic                     axis_arvalid;
   logic                     axis_arready;
   logic [P_AXI_IDWIDTH-1:0] axis_rid;
   logic [63:0]              axis_rdata;
   logic [1:0]               axis_rresp;
   logic                     axis_rlast;
   logic                     axis_rvalid;
   logic                     axis_rready;

   modport slave (
      input  axis_awaddr, axis_awlen, axis_awsize, axis_awburst, axis_awid, axis_awvalid,
      output axis_awready,
      input  axis_wdata, axis_wstrb, axis_wlast, axis_wvalid,
      output axis_wready,
      output axis_bid, axis_bresp, axis_bvalid,
      input  axis_bready,
      input  axis_araddr, axis_arlen, axis_arsize, axis_arburst, axis_arid, axis_arvalid,
      output axis_arready,
      output axis_rid, axis_rdata, axis_rresp, axis_rlast, axis_rvalid,
      input  axis_rready
   );

   modport master (
      output axis_awaddr, axis_awlen, axis_awsize, axis_awburst, axis_awid, axis_awvalid,
      input  axis_awready,
      output axis_wdata, axis_wstrb, axis_wlast, axis_wvalid,
      input  axis_wready,
      input  axis_bid, axis_bresp, axis_bvalid,
      output axis_bready,
      output axis_araddr, axis_arlen, axis_arsize, axis_arburst, axis_arid, axis_arvalid,
      input  axis_arready,
      input  axis_rid, axis_rdata, axis_rresp, axis_rlast, axis_rvalid,
      output axis_rready
   );
endinterface

// File: rtl/axi64_sram_slave.sv
// AXI3 64-bit slave onto a single-port 1-cycle-latency SRAM; independent read and
// write FSMs share the SRAM port with the read strobe taking priority.
module axi64_sram_slave #(
   parameter int          P_AXI_IDWIDTH  = 5,
   parameter int          P_MEM_AW       = 10,
   parameter logic [31:0] P_ADDRESS_BASE = 32'h00000000
) (
   input  logic                clk,
   input  logic                aresetn,
   axi64_sram_slave_if.slave   axis,
   output logic                mem_en,
   output logic [7:0]          mem_we,
   output logic [P_MEM_AW-1:0] mem_addr,
   output logic [63:0]         mem_wdata,
   input  logic [63:0]         mem_rdata
);
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OK    = 2'b00;
   localparam logic [1:0] RESP_SLV   = 2'b10;

   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_WAIT, RD_DATA} rd_state_t;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   // Keeps the address-channel readies low while reset is held and for the release edge.
   logic up_q;

   logic [31:0]              wr_addr, rd_addr;
   logic [7:0]               wr_len, wr_beat;
   logic [3:0]               rd_len, rd_beat;
   logic [P_AXI_IDWIDTH-1:0] wr_id, rd_id;
   logic                     wr_cfg_err, wr_err, rd_cfg_err, rd_beat_err;
   logic [1:0]               bresp_q, rresp_q;
   logic [63:0]              rdata_q;
   logic                     rlast_q;

   logic [31:0] wr_off, rd_off;
   logic        wr_beat_err, wr_last, wr_hs, wr_strobe, rd_strobe;
   logic        aw_rdy, w_rdy, b_vld, ar_rdy;
   logic        unused_low;

   assign wr_off      = wr_addr - P_ADDRESS_BASE;
   assign rd_off      = rd_addr - P_ADDRESS_BASE;
   assign unused_low  = ^{wr_off[2:0], rd_off[2:0]};
   assign wr_beat_err = wr_cfg_err | (wr_off[31:P_MEM_AW+3] != '0);
   assign wr_last     = (wr_beat == wr_len);
   assign rd_strobe   = (rd_state == RD_FETCH) & ~rd_cfg_err & (rd_off[31:P_MEM_AW+3] == '0);

   always_ff @(posedge clk or negedge aresetn)
      if (!aresetn) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
         up_q     <= 1'b0;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
         up_q     <= 1'b1;
      end

   always_comb begin
      wr_next = wr_state;
      aw_rdy  = 1'b0;
      w_rdy   = 1'b0;
      b_vld   = 1'b0;
      wr_hs   = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            aw_rdy = up_q;
            if (up_q && axis.axis_awvalid) wr_next = WR_DATA;
         end
         WR_DATA: begin
            w_rdy = ~rd_strobe;
            wr_hs = axis.axis_wvalid & ~rd_strobe;
            if (wr_hs && wr_last) wr_next = WR_RESP;
         end
         WR_RESP: begin
            b_vld = 1'b1;
            if (axis.axis_bready) wr_next = WR_IDLE;
         end
         default: wr_next = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_next = rd_state;
      ar_rdy  = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            ar_rdy = up_q;
            if (up_q && axis.axis_arvalid) rd_next = RD_FETCH;
         end
         RD_FETCH: rd_next = RD_WAIT;
         RD_WAIT:  rd_next = RD_DATA;
         RD_DATA:  if (axis.axis_rready) rd_next = rlast_q ? RD_IDLE : RD_FETCH;
         default:  rd_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn)
      if (!aresetn) begin
         wr_addr    <= '0;
         wr_len     <= '0;
         wr_beat    <= '0;
         wr_id      <= '0;
         wr_cfg_err <= 1'b0;
         wr_err     <= 1'b0;
         bresp_q    <= RESP_OK;
      end else if (wr_state == WR_IDLE && wr_next == WR_DATA) begin
         wr_addr    <= axis.axis_awaddr;
         wr_len     <= axis.axis_awlen;
         wr_id      <= axis.axis_awid;
         wr_cfg_err <= (axis.axis_awsize != 3'd3) | (axis.axis_awburst != BURST_INCR);
         wr_beat    <= '0;
         wr_err     <= 1'b0;
      end else if (wr_hs) begin
         wr_addr <= wr_addr + 32'd8;
         wr_beat <= wr_beat + 8'd1;
         // A missing wlast on the counted final beat is reported, not used for framing.
         if (wr_beat_err || (wr_last && !axis.axis_wlast)) wr_err <= 1'b1;
         if (wr_last)
            bresp_q <= (wr_err || wr_beat_err || !axis.axis_wlast) ? RESP_SLV : RESP_OK;
      end

   always_ff @(posedge clk or negedge aresetn)
      if (!aresetn) begin
         rd_addr     <= '0;
         rd_len      <= '0;
         rd_beat     <= '0;
         rd_id       <= '0;
         rd_cfg_err  <= 1'b0;
         rd_beat_err <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= RESP_OK;
         rlast_q     <= 1'b0;
      end else begin
         case (rd_state)
            RD_IDLE: if (rd_next == RD_FETCH) begin
               rd_addr    <= axis.axis_araddr;
               rd_len     <= axis.axis_arlen;
               rd_id      <= axis.axis_arid;
               rd_cfg_err <= (axis.axis_arsize != 3'd3) | (axis.axis_arburst != BURST_INCR);
               rd_beat    <= '0;
            end
            RD_FETCH: rd_beat_err <= ~rd_strobe;
            RD_WAIT: begin
               rdata_q <= rd_beat_err ? 64'd0 : mem_rdata;
               rresp_q <= rd_beat_err ? RESP_SLV : RESP_OK;
               rlast_q <= (rd_beat == rd_len);
            end
            RD_DATA: if (axis.axis_rready) begin
               rlast_q <= 1'b0;
               if (!rlast_q) begin
                  rd_addr <= rd_addr + 32'd8;
                  rd_beat <= rd_beat + 4'd1;
               end
            end
            default: ;
         endcase
      end

   assign wr_strobe = wr_hs & ~wr_beat_err;
   assign mem_en    = rd_strobe | wr_strobe;
   assign mem_we    = wr_strobe ? axis.axis_wstrb : 8'h00;
   assign mem_addr  = rd_strobe ? rd_off[P_MEM_AW+2:3] : wr_off[P_MEM_AW+2:3];
   assign mem_wdata = wr_strobe ? axis.axis_wdata : 64'd0;

   assign axis.axis_awready = aw_rdy;
   assign axis.axis_wready  = w_rdy;
   assign axis.axis_bvalid  = b_vld;
   assign axis.axis_bid     = wr_id;
   assign axis.axis_bresp   = b_vld ? bresp_q : RESP_OK;
   assign axis.axis_arready = ar_rdy;
   assign axis.axis_rvalid  = (rd_state == RD_DATA);
   assign axis.axis_rid     = rd_id;
   assign axis.axis_rdata   = rdata_q;
   assign axis.axis_rresp   = rresp_q;
   assign axis.axis_rlast   = rlast_q & (rd_state == RD_DATA);
endmodule

// File: tb/tb_axi64_sram_slave.sv
// Directed bench for axi64_sram_slave with a behavioural SRAM and access counters.
module tb_axi64_sram_slave;
   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   axi64_sram_slave_if #(.P_AXI_IDWIDTH(5)) axis();

   logic        mem_en;
   logic [7:0]  mem_we;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   axi64_sram_slave #(.P_AXI_IDWIDTH(5), .P_MEM_AW(10), .P_ADDRESS_BASE(32'h0)) dut (
      .clk(clk), .aresetn(aresetn), .axis(axis),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [63:0] sram [0:1023];
   logic        init_done = 1'b0;
   int          cyc = 0, n_wr = 0, n_rd = 0, rd_cyc = 0;
   logic [9:0]  lw_addr = '0, lr_addr = '0;
   logic [63:0] lw_data = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) sram[i] <= '0;
         init_done <= 1'b1;
      end else if (mem_en) begin
         if (mem_we != 8'h00) begin
            for (int b = 0; b < 8; b++)
               if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            n_wr    <= n_wr + 1;
            lw_addr <= mem_addr;
            lw_data <= mem_wdata;
         end else begin
            mem_rdata <= sram[mem_addr];
            n_rd      <= n_rd + 1;
            lr_addr   <= mem_addr;
            rd_cyc    <= cyc;
         end
      end
   end

   int checks = 0, passes = 0, fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [4:0] id);
      int n;
      n = 0;
      @(negedge clk);
      axis.axis_awaddr = a; axis.axis_awlen = len; axis.axis_awsize = sz;
      axis.axis_awburst = 2'b01; axis.axis_awid = id; axis.axis_awvalid = 1'b1;
      #1;
      while (!axis.axis_awready && n < 20) begin @(negedge clk); #1; n++; end
      chk("aw_accept", 64'(n < 20), 64'd1);
      @(negedge clk); axis.axis_awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [3:0] len, input logic [4:0] id);
      int n;
      n = 0;
      @(negedge clk);
      axis.axis_araddr = a; axis.axis_arlen = len; axis.axis_arsize = 3'd3;
      axis.axis_arburst = 2'b01; axis.axis_arid = id; axis.axis_arvalid = 1'b1;
      #1;
      while (!axis.axis_arready && n < 20) begin @(negedge clk); #1; n++; end
      chk("ar_accept", 64'(n < 20), 64'd1);
      @(negedge clk); axis.axis_arvalid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      axis.axis_wdata = d; axis.axis_wstrb = strb; axis.axis_wlast = last; axis.axis_wvalid = 1'b1;
      #1;
      while (!axis.axis_wready && n < 20) begin @(negedge clk); #1; n++; end
      chk("w_accept", 64'(n < 20), 64'd1);
      @(negedge clk); axis.axis_wvalid = 1'b0;
   endtask

   task automatic wait_b(input logic [4:0] id, input logic [1:0] resp);
      int n;
      n = 0;
      @(negedge clk);
      axis.axis_bready = 1'b1;
      #1;
      while (!axis.axis_bvalid && n < 20) begin @(negedge clk); #1; n++; end
      chk("b_valid", 64'(n < 20), 64'd1);
      chk("bid", 64'(axis.axis_bid), 64'(id));
      chk("bresp", 64'(axis.axis_bresp), 64'(resp));
      @(negedge clk); axis.axis_bready = 1'b0;
   endtask

   task automatic recv_r(input logic [63:0] d, input logic [1:0] resp, input logic last,
                         input logic [4:0] id, input int hold, output int seen);
      int n, nr;
      n = 0;
      @(negedge clk);
      axis.axis_rready = (hold == 0);
      #1;
      while (!axis.axis_rvalid && n < 20) begin @(negedge clk); #1; n++; end
      chk("r_valid", 64'(n < 20), 64'd1);
      seen = cyc;
      chk("rdata", axis.axis_rdata, d);
      chk("rresp", 64'(axis.axis_rresp), 64'(resp));
      chk("rlast", 64'(axis.axis_rlast), 64'(last));
      chk("rid", 64'(axis.axis_rid), 64'(id));
      if (hold > 0) begin
         nr = n_rd;
         repeat (hold) begin
            @(negedge clk); #1;
            chk("r_hold_data", axis.axis_rdata, d);
            chk("r_hold_valid", 64'(axis.axis_rvalid), 64'd1);
         end
         chk("r_hold_no_strobe", 64'(n_rd), 64'(nr));
         axis.axis_rready = 1'b1;
      end
      @(negedge clk); axis.axis_rready = 1'b0;
   endtask

   localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] D3 = 64'hCAFE_F00D_1234_5678;

   initial begin
      int seen, nw, nr;
      axis.axis_awaddr = '0; axis.axis_awlen = '0; axis.axis_awsize = '0; axis.axis_awburst = '0;
      axis.axis_awid = '0; axis.axis_awvalid = 1'b0;
      axis.axis_wdata = '0; axis.axis_wstrb = '0; axis.axis_wlast = 1'b0; axis.axis_wvalid = 1'b0;
      axis.axis_bready = 1'b0;
      axis.axis_araddr = '0; axis.axis_arlen = '0; axis.axis_arsize = '0; axis.axis_arburst = '0;
      axis.axis_arid = '0; axis.axis_arvalid = 1'b0; axis.axis_rready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_awready", 64'(axis.axis_awready), 64'd0);
      chk("rst_arready", 64'(axis.axis_arready), 64'd0);
      chk("rst_wready", 64'(axis.axis_wready), 64'd0);
      chk("rst_bvalid", 64'(axis.axis_bvalid), 64'd0);
      chk("rst_rvalid", 64'(axis.axis_rvalid), 64'd0);
      chk("rst_rlast", 64'(axis.axis_rlast), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_bid", 64'(axis.axis_bid), 64'd0);
      chk("rst_rdata", axis.axis_rdata, 64'd0);
      @(negedge clk); aresetn = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_awready", 64'(axis.axis_awready), 64'd1);
      chk("post_rst_arready", 64'(axis.axis_arready), 64'd1);

      // single write, word 2, low four bytes
      send_aw(32'h10, 8'd0, 3'd3, 5'd5);
      send_w(64'h1122334455667788, 8'h0F, 1'b1);
      chk("single_wr_count", 64'(n_wr), 64'd1);
      chk("single_wr_addr", 64'(lw_addr), 64'd2);
      chk("single_wr_data", lw_data, 64'h1122334455667788);
      chk("single_wr_mem", sram[2], 64'h0000000055667788);
      wait_b(5'd5, 2'b00);

      // read-back of word 2
      send_ar(32'h10, 4'd0, 5'd3);
      recv_r(64'h0000000055667788, 2'b00, 1'b1, 5'd3, 0, seen);
      chk("rb_rd_addr", 64'(lr_addr), 64'd2);
      chk("rb_latency", 64'((seen - rd_cyc) >= 2), 64'd1);

      // INCR burst write to words 1..4
      nw = n_wr;
      send_aw(32'h8, 8'd3, 3'd3, 5'd7);
      send_w(D0, 8'hFF, 1'b0);
      send_w(D1, 8'hFF, 1'b0);
      send_w(D2, 8'hFF, 1'b0);
      send_w(D3, 8'hFF, 1'b1);
      wait_b(5'd7, 2'b00);
      chk("burst_wr_count", 64'(n_wr - nw), 64'd4);
      chk("burst_wr_last_addr", 64'(lw_addr), 64'd4);

      // INCR burst read, beat 2 held off for 5 cycles
      send_ar(32'h8, 4'd3, 5'd9);
      recv_r(D0, 2'b00, 1'b0, 5'd9, 0, seen);
      recv_r(D1, 2'b00, 1'b0, 5'd9, 5, seen);
      recv_r(D2, 2'b00, 1'b0, 5'd9, 0, seen);
      recv_r(D3, 2'b00, 1'b1, 5'd9, 0, seen);
      chk("burst_rd_last_addr", 64'(lr_addr), 64'd4);

      // bad size on write: beats consumed, no memory write, SLVERR
      nw = n_wr;
      send_aw(32'h40, 8'd1, 3'd2, 5'd11);
      send_w(64'hAAAA, 8'hFF, 1'b0);
      send_w(64'hBBBB, 8'hFF, 1'b1);
      wait_b(5'd11, 2'b10);
      chk("err_wr_no_write", 64'(n_wr), 64'(nw));

      // read just past the top of memory
      nr = n_rd;
      send_ar(32'h2000, 4'd0, 5'd4);
      recv_r(64'd0, 2'b10, 1'b1, 5'd4, 0, seen);
      chk("err_rd_no_strobe", 64'(n_rd), 64'(nr));

      // AR and AW/W together: the read strobe goes first
      @(negedge clk);
      axis.axis_awaddr = 32'h30; axis.axis_awlen = 8'd0; axis.axis_awsize = 3'd3;
      axis.axis_awburst = 2'b01; axis.axis_awid = 5'd6; axis.axis_awvalid = 1'b1;
      axis.axis_araddr = 32'h18; axis.axis_arlen = 4'd0; axis.axis_arsize = 3'd3;
      axis.axis_arburst = 2'b01; axis.axis_arid = 5'd2; axis.axis_arvalid = 1'b1;
      axis.axis_wdata = 64'h5555_6666_7777_8888; axis.axis_wstrb = 8'hFF;
      axis.axis_wlast = 1'b1; axis.axis_wvalid = 1'b1;
      #1;
      chk("coll_awready", 64'(axis.axis_awready), 64'd1);
      chk("coll_arready", 64'(axis.axis_arready), 64'd1);
      @(negedge clk);
      axis.axis_awvalid = 1'b0; axis.axis_arvalid = 1'b0;
      #1;
      chk("coll_wready_blocked", 64'(axis.axis_wready), 64'd0);
      chk("coll_rd_strobe", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 8'h00, 10'd3}));
      @(negedge clk); #1;
      chk("coll_wready_open", 64'(axis.axis_wready), 64'd1);
      chk("coll_wr_strobe", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 8'hFF, 10'd6}));
      @(negedge clk); axis.axis_wvalid = 1'b0;
      wait_b(5'd6, 2'b00);
      recv_r(D2, 2'b00, 1'b1, 5'd2, 0, seen);
      chk("coll_wr_mem", sram[6], 64'h5555_6666_7777_8888);

      // reset during beat 2 of a 4-beat write
      send_aw(32'h100, 8'd3, 3'd3, 5'd1);
      send_w(64'h1111, 8'hFF, 1'b0);
      @(negedge clk);
      axis.axis_wdata = 64'h2222; axis.axis_wstrb = 8'hFF; axis.axis_wlast = 1'b0;
      axis.axis_wvalid = 1'b1;
      aresetn = 1'b0;
      #1;
      chk("mid_rst_awready", 64'(axis.axis_awready), 64'd0);
      chk("mid_rst_wready", 64'(axis.axis_wready), 64'd0);
      chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
      chk("mid_rst_bvalid", 64'(axis.axis_bvalid), 64'd0);
      nw = n_wr;
      repeat (2) @(negedge clk);
      #1;
      chk("mid_rst_no_write", 64'(n_wr), 64'(nw));
      @(negedge clk);
      aresetn = 1'b1; axis.axis_wvalid = 1'b0;
      @(negedge clk); #1;
      chk("after_rst_awready", 64'(axis.axis_awready), 64'd1);
      chk("after_rst_no_write", 64'(n_wr), 64'(nw));
      send_aw(32'h20, 8'd0, 3'd3, 5'd10);
      send_w(64'h0BAD_F00D_C0DE_0042, 8'hFF, 1'b1);
      wait_b(5'd10, 2'b00);
      chk("after_rst_wr_addr", 64'(lw_addr), 64'd4);
      chk("after_rst_wr_mem", sram[4], 64'h0BAD_F00D_C0DE_0042);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/axi64_sram_slave.md
Name: axi64_sram_slave

Overview:
- AXI3-style 64-bit slave that terminates the AXI master port of the AHB-to-AXI debug bridge.
- Maps AXI read/write transactions, single-beat or INCR bursts, onto one single-port synchronous SRAM-style port with 1-cycle read latency.
- Used as an MDDR stand-in and debug memory so the bridge and its software can be brought up without the DDR controller.

Parameters:
- P_AXI_IDWIDTH, 5: width of all AXI ID fields.
- P_MEM_AW, 10: SRAM word-address width; memory holds 2^P_MEM_AW 64-bit words.
- P_ADDRESS_BASE, 32'h00000000: byte address of SRAM word 0; must be 8-byte aligned.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- axis_awaddr  in  32  write byte address
- axis_awlen  in  8  write beats minus 1
- axis_awsize  in  3  write beat size
- axis_awburst  in  2  write burst type
- axis_awid  in  P_AXI_IDWIDTH  write ID
- axis_awvalid  in  1  AW valid
- axis_awready  out  1  AW ready
- axis_wdata  in  64  write data
- axis_wstrb  in  8  byte strobes
- axis_wlast  in  1  last write beat
- axis_wvalid  in  1  W valid
- axis_wready  out  1  W ready
- axis_bid  out  P_AXI_IDWIDTH  response ID
- axis_bresp  out  2  write response
- axis_bvalid  out  1  B valid
- axis_bready  in  1  B ready
- axis_araddr  in  32  read byte address
- axis_arlen  in  4  read beats minus 1
- axis_arsize  in  3  read beat size
- axis_arburst  in  2  read burst type
- axis_arid  in  P_AXI_IDWIDTH  read ID
- axis_arvalid  in  1  AR valid
- axis_arready  out  1  AR ready
- axis_rid  out  P_AXI_IDWIDTH  read ID
- axis_rdata  out  64  read data
- axis_rresp  out  2  read response
- axis_rlast  out  1  last read beat
- axis_rvalid  out  1  R valid
- axis_rready  in  1  R ready
- mem_en  out  1  SRAM access strobe
- mem_we  out  8  SRAM byte write enables
- mem_addr  out  P_MEM_AW  SRAM word address
- mem_wdata  out  64  SRAM write data
- mem_rdata  in  64  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Reset:
  - All ready, valid, last and mem_en/mem_we outputs 0.
  - bid, bresp, rid, rresp and rdata are 0.
  - Both FSMs return to IDLE.
  - Reset mid-burst abandons the burst; no further memory access occurs.
- Write FSM, states WR_IDLE, WR_DATA, WR_RESP:
  - WR_IDLE: awready=1. On awvalid, latch addr, len, id and err_cfg, then go to WR_DATA.
  - err_cfg = (awsize!=3) | (awburst!=INCR).
  - WR_DATA: wready=1 unless a read strobe holds the SRAM this cycle (see Arbitration).
  - On each W handshake with no error: mem_en=1, mem_we=wstrb, mem_addr = word index of current address, mem_wdata=wdata. Then address += 8, 32-bit wrap.
  - Beat error = err_cfg or address outside [P_ADDRESS_BASE, P_ADDRESS_BASE + 8*2^P_MEM_AW). An error beat is consumed with no SRAM write.
  - Beat count is taken from awlen; wlast is ignored for counting. wlast mismatch on the final beat sets the error flag.
  - After the final beat, go to WR_RESP with bvalid=1, bid=latched id, bresp = 2'b10 (SLVERR) if any beat errored, else 2'b00.
  - bvalid holds until bready; the handshake returns the FSM to WR_IDLE. awready is asserted again on the next cycle.
- Read FSM, states RD_IDLE, RD_FETCH, RD_WAIT, RD_DATA:
  - RD_IDLE: arready=1. On arvalid, latch addr, len, id and err_cfg, then go to RD_FETCH.
  - RD_FETCH: if the SRAM is free, issue mem_en=1, mem_we=0 for the current address and go to RD_WAIT. Error beats issue no strobe and also go to RD_WAIT.
  - RD_WAIT: capture mem_rdata into rdata (0 on error beats), set rresp (2'b10 on error, else 2'b00) and rlast = (beat==len), rvalid=1, then go to RD_DATA.
  - RD_DATA: hold rdata, rresp, rlast and rvalid until rready. On handshake: if last beat, go to RD_IDLE; else address += 8 and go to RD_FETCH.
  - Throughput is one beat per 3 cycles. This is intentional for a debug path.
  - rid = latched id for every beat of the burst.
- Arbitration:
  - Only one SRAM access per cycle.
  - A read strobe in RD_FETCH has priority; it is a single cycle, so writes can never be starved.
  - In a cycle where a read strobe fires, wready=0.
- Concurrency:
  - The read and write FSMs run independently; AW and AR may be accepted in the same cycle.
  - A W beat arriving before AW is not accepted; wready=0 in WR_IDLE.
- Word index = (addr - P_ADDRESS_BASE) >> 3, truncated to P_MEM_AW bits after the range check.

Test Plan:
- Single write: AW addr=BASE+0x10, len=0, size=3, id=5; W data=64'h1122334455667788, strb=8'h0F -> one mem write with addr=2, we=0F; bresp=00, bid=5.
- Read-back: AR addr=BASE+0x10, len=0, id=3 -> mem read of addr=2; rdata = SRAM content, rlast=1, rresp=00, rid=3; no R beat before the strobe cycle+1.
- INCR burst: AW len=3 at BASE+0x8 -> writes to addrs 1,2,3,4. Then AR len=3 -> 4 R beats, rlast only on beat 4. Hold rready=0 for 5 cycles on beat 2 -> rdata stable, no extra mem strobes.
- Errors:
  - AW size=2 -> all beats consumed, no mem_we, bresp=10.
  - AR at BASE + 8*2^P_MEM_AW -> rdata=0, rresp=10, no mem_en.
- Collision: AR and AW/W presented in the same cycle -> read strobe first with wready=0 for one cycle, then the write proceeds; both responses are correct.
- Reset mid-burst: assert aresetn=0 during beat 2 of a 4-beat write -> all outputs 0 immediately; after release, awready=1 and a fresh transaction completes normally.
